// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: shared tags, header offsets and helpers
// for the UDP receive parser.
package udp_rx_pkg;

  localparam logic [1:0] TAG_DATA     = 2'b00;
  localparam logic [1:0] TAG_HDR      = 2'b01;
  localparam logic [1:0] TAG_TRL      = 2'b10;
  localparam logic [1:0] TAG_LAST_ODD = 2'b11;

  localparam logic [5:0] OFF_MAC_END  = 6'h05;
  localparam logic [5:0] OFF_ETYPE_HI = 6'h0c;
  localparam logic [5:0] OFF_ETYPE_LO = 6'h0d;
  localparam logic [5:0] OFF_VIHL     = 6'h0e;
  localparam logic [5:0] OFF_TOS      = 6'h0f;
  localparam logic [5:0] OFF_ID_LO    = 6'h13;
  localparam logic [5:0] OFF_PROTO    = 6'h17;
  localparam logic [5:0] OFF_DIP_HI   = 6'h1e;
  localparam logic [5:0] OFF_DIP_LO   = 6'h21;
  localparam logic [5:0] OFF_PORT_HI  = 6'h24;
  localparam logic [5:0] OFF_PORT_LO  = 6'h25;
  localparam logic [5:0] OFF_ULEN_LO  = 6'h27;
  localparam logic [5:0] OFF_MAGIC_HI = 6'h2a;
  localparam logic [5:0] OFF_MAGIC_LO = 6'h2d;

  // UDP header (8) plus magic (4) precede the forwarded payload
  localparam logic [15:0] UDP_OVERHEAD = 16'd12;
  localparam logic [31:0] CRC_RESIDUE  = 32'hc704dd7b;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_TAIL,
    S_TRAILER,
    S_DROP
  } state_t;

  function automatic logic [7:0] byte_of(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    unique case (i)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // active-high segments, gfedcba
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    unique case (v)
      4'h0: return 7'h3f;
      4'h1: return 7'h06;
      4'h2: return 7'h5b;
      4'h3: return 7'h4f;
      4'h4: return 7'h66;
      4'h5: return 7'h6d;
      4'h6: return 7'h7d;
      4'h7: return 7'h07;
      4'h8: return 7'h7f;
      4'h9: return 7'h6f;
      4'ha: return 7'h77;
      4'hb: return 7'h7c;
      4'hc: return 7'h39;
      4'hd: return 7'h5e;
      4'he: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/udp_rx_parser_crc32_chk.sv
// crc32_chk: reflected Ethernet CRC-32 over the frame,
// flags the good-FCS residue.
module crc32_chk
  import udp_rx_pkg::*;
(
  input  logic       pcie_clk,
  input  logic       sys_rst,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] data,
  output logic       residue_ok
);

  logic [31:0] crc;
  logic [31:0] crc_nx;
  logic [31:0] rev;

  always_comb begin
    crc_nx = init ? 32'hffff_ffff : crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_nx[0] ^ data[i])
        crc_nx = (crc_nx >> 1) ^ 32'hedb8_8320;
      else
        crc_nx = crc_nx >> 1;
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (sys_rst)
      crc <= 32'hffff_ffff;
    else if (init || en)
      crc <= crc_nx;
  end

  // residue constant is quoted in MSB-first order
  always_comb begin
    rev = '0;
    for (int i = 0; i < 32; i++)
      rev[i] = crc[31-i];
  end

  assign residue_ok = (rev == CRC_RESIDUE);

endmodule

// File: rtl/udp_rx_parser.sv
// udp_rx_parser: Ethernet/IPv4/UDP receive parser that
// forwards tagged payload words to the slave FIFO.
module udp_rx_parser
  import udp_rx_pkg::*;
#(
  parameter logic [47:0] OWN_MAC      = 48'h003776_000002,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [31:0] OWN_IP       = {8'd10, 8'd0, 8'd21, 8'd254},
  parameter logic [15:0] UDP_PORT     = 16'h0d5e,
  parameter logic [31:0] MAGIC        = 32'ha1110000
) (
  input  logic        pcie_clk,
  input  logic        sys_rst,
  input  logic [8:0]  phy_dout,
  input  logic        phy_empty,
  output logic        phy_rd_en,
  output logic [17:0] slv_din,
  input  logic        slv_full,
  output logic        slv_wr_en,
  input  logic [7:0]  dipsw,
  input  logic        btn,
  output logic [7:0]  led,
  output logic [13:0] segled
);

  state_t      state, state_nx;
  logic        rd_q, skid_vld, pend;
  logic        phase, trunc, own_q, bc_q;
  logic [8:0]  skid, cur;
  logic [17:0] word, ld_word;
  logic [5:0]  off, oc;
  logic [1:0]  qi;
  logic [7:0]  hold, b, mac_b, port_b;
  logic [15:0] id, ulen, csum, cnt;
  logic [15:0] good, drop, shown;
  logic [16:0] sum17;
  logic [15:0] csum_add, csum_nx;
  logic        have, stall, go, dv, hdr;
  logic        own_m, bc_m, bad, ld;
  logic        good_inc, drop_inc, crc_ok;
  logic        unused_bits;

  assign cur   = skid_vld ? skid : phy_dout;
  assign have  = skid_vld || rd_q;
  assign dv    = cur[8];
  assign b     = cur[7:0];
  assign stall = have &&
                 ((pend && slv_full) ||
                  state == S_TRAILER);
  assign go    = have && !stall;
  assign hdr   = (state == S_IDLE) ||
                 (state == S_HDR);
  assign oc    = (state == S_IDLE) ? '0 : off;
  assign qi    = oc[1:0] - 2'd2;

  assign phy_rd_en = !sys_rst && !phy_empty &&
                     !skid_vld &&
                     !(pend && slv_full) &&
                     state != S_TRAILER;
  assign slv_wr_en = !sys_rst && pend && !slv_full;
  assign slv_din   = word;

  always_comb begin
    unique case (oc[2:0])
      3'd0:    mac_b = OWN_MAC[47:40];
      3'd1:    mac_b = OWN_MAC[39:32];
      3'd2:    mac_b = OWN_MAC[31:24];
      3'd3:    mac_b = OWN_MAC[23:16];
      3'd4:    mac_b = OWN_MAC[15:8];
      default: mac_b = OWN_MAC[7:0];
    endcase
  end

  assign port_b = oc[0] ? UDP_PORT[7:0]
                        : UDP_PORT[15:8];
  assign own_m  = (oc == '0 || own_q) &&
                  b == mac_b;
  assign bc_m   = ACCEPT_BCAST &&
                  (oc == '0 || bc_q) &&
                  b == 8'hff;

  // running one's-complement sum, folded each halfword
  assign sum17    = {1'b0, csum} + {1'b0, hold, b};
  assign csum_add = sum17[15:0] + {15'b0, sum17[16]};
  assign csum_nx  = (oc[0] && oc >= OFF_TOS &&
                     oc <= OFF_DIP_LO)
                    ? csum_add : csum;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      oc <= OFF_MAC_END:
        bad = !(own_m || bc_m);
      oc == OFF_ETYPE_HI: bad = b != 8'h08;
      oc == OFF_ETYPE_LO: bad = b != 8'h00;
      oc == OFF_VIHL:     bad = b != 8'h45;
      oc == OFF_TOS:      bad = b != 8'h00;
      oc == OFF_PROTO:    bad = b != 8'h11;
      oc >= OFF_DIP_HI && oc <= OFF_DIP_LO:
        bad = b != byte_of(OWN_IP, qi) ||
              (oc == OFF_DIP_LO &&
               csum_nx != 16'hffff);
      oc == OFF_PORT_HI || oc == OFF_PORT_LO:
        bad = b != port_b;
      oc >= OFF_MAGIC_HI:
        bad = b != byte_of(MAGIC, qi);
      default: bad = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_word  = '0;
    good_inc = 1'b0;
    drop_inc = 1'b0;
    unique case (state)
      S_IDLE:
        if (go && dv)
          state_nx = bad ? S_DROP : S_HDR;
      S_HDR:
        if (go) begin
          if (!dv) begin
            state_nx = S_IDLE;
            drop_inc = 1'b1;
          end else if (bad) begin
            state_nx = S_DROP;
          end else if (oc == OFF_MAGIC_LO) begin
            ld       = 1'b1;
            ld_word  = {TAG_HDR, id};
            state_nx = (ulen <= UDP_OVERHEAD)
                       ? S_TAIL : S_PAYLOAD;
          end
        end
      S_PAYLOAD:
        if (go) begin
          if (!dv) begin
            ld       = phase;
            ld_word  = {TAG_LAST_ODD, hold, 8'h00};
            state_nx = S_TRAILER;
          end else if (!phase) begin
            if (cnt == 16'd1) begin
              ld       = 1'b1;
              ld_word  = {TAG_LAST_ODD, b, 8'h00};
              state_nx = S_TAIL;
            end
          end else begin
            ld      = 1'b1;
            ld_word = {TAG_DATA, hold, b};
            if (cnt == 16'd1)
              state_nx = S_TAIL;
          end
        end
      S_TAIL:
        if (go && !dv)
          state_nx = S_TRAILER;
      S_TRAILER:
        if (!(pend && slv_full)) begin
          ld       = 1'b1;
          ld_word  = {TAG_TRL, 14'b0, trunc, crc_ok};
          good_inc = crc_ok && !trunc;
          state_nx = S_IDLE;
        end
      S_DROP:
        if (go && !dv) begin
          state_nx = S_IDLE;
          drop_inc = 1'b1;
        end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (sys_rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      rd_q     <= 1'b0;
      skid_vld <= 1'b0;
      skid     <= '0;
      pend     <= 1'b0;
      word     <= '0;
      off      <= '0;
      hold     <= '0;
      id       <= '0;
      ulen     <= '0;
      csum     <= '0;
      cnt      <= '0;
      phase    <= 1'b0;
      trunc    <= 1'b0;
      own_q    <= 1'b0;
      bc_q     <= 1'b0;
    end else begin
      rd_q     <= phy_rd_en;
      skid_vld <= stall;
      if (stall)
        skid <= cur;
      if (ld) begin
        pend <= 1'b1;
        word <= ld_word;
      end else if (slv_wr_en) begin
        pend <= 1'b0;
      end
      if (go && dv)
        hold <= b;
      if (go && dv && hdr) begin
        off  <= oc + 6'd1;
        csum <= (oc == '0) ? '0 : csum_nx;
        if (oc <= OFF_MAC_END) begin
          own_q <= own_m;
          bc_q  <= bc_m;
        end
        if (oc == '0)
          trunc <= 1'b0;
        if (oc == OFF_ID_LO)
          id <= {hold, b};
        if (oc == OFF_ULEN_LO)
          ulen <= {hold, b};
        if (oc == OFF_MAGIC_LO) begin
          cnt   <= ulen - UDP_OVERHEAD;
          phase <= 1'b0;
        end
      end
      if (go && state == S_PAYLOAD) begin
        if (dv) begin
          cnt   <= cnt - 16'd1;
          phase <= ~phase;
        end else begin
          trunc <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (sys_rst || btn) begin
      good <= '0;
      drop <= '0;
    end else begin
      if (good_inc)
        good <= good + 16'd1;
      if (drop_inc)
        drop <= drop + 16'd1;
    end
  end

  crc32_chk u_crc (
    .pcie_clk   (pcie_clk),
    .sys_rst    (sys_rst),
    .init       (go && dv && state == S_IDLE),
    .en         (go && dv && state != S_IDLE),
    .data       (b),
    .residue_ok (crc_ok)
  );

  assign shown  = dipsw[0] ? drop : good;
  assign led    = ~good[7:0];
  assign segled = {~hex7seg(shown[7:4]),
                   ~hex7seg(shown[3:0])};

  assign unused_bits = ^{dipsw[7:1], shown[15:8]};

endmodule
